// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset controller: registered state plus combinational
// decode of datapath controls, with memory-ready stalls on fetch and data access.
module multicycle_control (
    input  logic       clk,
    input  logic       arst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_2_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXECUTE   = 4'd7,
        ALU_WB    = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10,
        ADDI_EX   = 4'd11,
        ADDI_WB   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t cur, nxt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) cur <= IDLE;
        else         cur <= nxt;
    end

    assign state = cur;

    always_comb begin
        nxt           = cur;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_2_reg     = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        case (cur)
            IDLE: nxt = FETCH;
            FETCH: begin
                // PC += 4 and IR load only commit on the cycle the read returns
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxt      = DECODE;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: nxt = MEM_ADDR;
                    OP_RTYPE:     nxt = EXECUTE;
                    OP_BEQ:       nxt = BRANCH;
                    OP_J:         nxt = JUMP;
                    OP_ADDI:      nxt = ADDI_EX;
                    default: begin
                        illegal_op = 1'b1;
                        nxt        = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) nxt = MEM_WB;
            end
            MEM_WB: begin
                mem_2_reg  = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    nxt        = FETCH;
                end
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                nxt       = ALU_WB;
            end
            ALU_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
                nxt           = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = ADDI_WB;
            end
            ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            default: nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its state sequence and checks state plus the full control word every cycle.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       arst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, ir_write, mem_read, mem_write;
    logic       mem_2_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    int n_run  = 0;
    int n_fail = 0;

    multicycle_control dut (
        .clk(clk), .arst_n(arst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_2_reg(mem_2_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
        .state(state)
    );

    always #5 clk = ~clk;

    // {pc_write,pc_write_cond,iord,ir_write,mem_read,mem_write,mem_2_reg,reg_dst,reg_write,alu_src_a}_asb_aop_psrc_done,ill
    logic [17:0] ctl;
    assign ctl = {pc_write, pc_write_cond, iord, ir_write, mem_read, mem_write,
                  mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source, instr_done, illegal_op};

    localparam logic [17:0] C_ZERO   = 18'b0000000000_00_00_00_00;
    localparam logic [17:0] C_F_RDY  = 18'b1001100000_01_00_00_00;
    localparam logic [17:0] C_F_WAIT = 18'b0000100000_01_00_00_00;
    localparam logic [17:0] C_DEC    = 18'b0000000000_11_00_00_00;
    localparam logic [17:0] C_DEC_IL = 18'b0000000000_11_00_00_01;
    localparam logic [17:0] C_MADDR  = 18'b0000000001_10_00_00_00;
    localparam logic [17:0] C_MREAD  = 18'b0010100000_00_00_00_00;
    localparam logic [17:0] C_MWB    = 18'b0000001010_00_00_00_10;
    localparam logic [17:0] C_MW_WT  = 18'b0010010000_00_00_00_00;
    localparam logic [17:0] C_MW_RDY = 18'b0010010000_00_00_00_10;
    localparam logic [17:0] C_EXEC   = 18'b0000000001_00_10_00_00;
    localparam logic [17:0] C_ALUWB  = 18'b0000000110_00_00_00_10;
    localparam logic [17:0] C_BRANCH = 18'b0100000001_00_01_01_10;
    localparam logic [17:0] C_JUMP   = 18'b1000000000_00_00_10_10;
    localparam logic [17:0] C_ADDIWB = 18'b0000000010_00_00_00_10;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic look(input string tag, input logic [3:0] es, input logic [17:0] ec);
        chk({tag, ".state"}, {28'd0, state}, {28'd0, es});
        chk({tag, ".ctl"}, {14'd0, ctl}, {14'd0, ec});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst_n = 1'b0; mem_ready = 1'b1; opcode = 6'h23;
        #2;  look("rst_async", 4'd0, C_ZERO);
        tick(); look("rst_hold", 4'd0, C_ZERO);
        #2 arst_n = 1'b1;
        #1 look("post_rel", 4'd0, C_ZERO);

        // lw with memory always ready
        tick(); look("lw.f",   4'd1, C_F_RDY);
        tick(); look("lw.d",   4'd2, C_DEC);
        tick(); look("lw.ma",  4'd3, C_MADDR);
        tick(); look("lw.mr",  4'd4, C_MREAD);
        tick(); look("lw.wb",  4'd5, C_MWB);
        tick(); look("lw.f2",  4'd1, C_F_RDY);

        // fetch stall for three cycles, then beq
        mem_ready = 1'b0; opcode = 6'h04;
        #0 look("stall.1", 4'd1, C_F_WAIT);
        tick(); look("stall.2", 4'd1, C_F_WAIT);
        tick(); look("stall.3", 4'd1, C_F_WAIT);
        tick(); mem_ready = 1'b1; #1 look("stall.4", 4'd1, C_F_RDY);
        tick(); look("beq.d",  4'd2, C_DEC);
        tick(); look("beq.br", 4'd9, C_BRANCH);
        tick(); look("beq.f",  4'd1, C_F_RDY);

        // sw with a 2-cycle write stall
        opcode = 6'h2B;
        tick(); look("sw.d",   4'd2, C_DEC);
        tick(); look("sw.ma",  4'd3, C_MADDR);
        tick(); mem_ready = 1'b0; #1 look("sw.w1", 4'd6, C_MW_WT);
        tick(); look("sw.w2",  4'd6, C_MW_WT);
        tick(); mem_ready = 1'b1; #1 look("sw.w3", 4'd6, C_MW_RDY);
        tick(); look("sw.f",   4'd1, C_F_RDY);

        // unsupported opcode
        opcode = 6'h3F;
        tick(); look("ill.d",  4'd2, C_DEC_IL);
        tick(); look("ill.f",  4'd1, C_F_RDY);

        // R-type
        opcode = 6'h00;
        tick(); look("r.d",    4'd2, C_DEC);
        tick(); look("r.ex",   4'd7, C_EXEC);
        tick(); look("r.wb",   4'd8, C_ALUWB);
        tick(); look("r.f",    4'd1, C_F_RDY);

        // addi
        opcode = 6'h08;
        tick(); look("addi.d",  4'd2, C_DEC);
        tick(); look("addi.ex", 4'd11, C_MADDR);
        tick(); look("addi.wb", 4'd12, C_ADDIWB);
        tick(); look("addi.f",  4'd1, C_F_RDY);

        // jump, with mem_ready low outside fetch to show it is ignored
        opcode = 6'h02;
        tick(); mem_ready = 1'b0; #1 look("j.d", 4'd2, C_DEC);
        tick(); look("j.j",    4'd10, C_JUMP);
        tick(); mem_ready = 1'b1; #1 look("j.f", 4'd1, C_F_RDY);

        // lw stalled in MEM_READ, then aborted by reset
        opcode = 6'h23;
        tick(); look("ab.d",   4'd2, C_DEC);
        tick(); look("ab.ma",  4'd3, C_MADDR);
        tick(); mem_ready = 1'b0; #1 look("ab.mr1", 4'd4, C_MREAD);
        tick(); look("ab.mr2", 4'd4, C_MREAD);
        #2 arst_n = 1'b0;
        #1 look("ab.rst",  4'd0, C_ZERO);
        mem_ready = 1'b1;
        tick(); look("ab.hold", 4'd0, C_ZERO);
        #2 arst_n = 1'b1;
        tick(); look("ab.f",   4'd1, C_F_RDY);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none; all encodings are fixed by this document.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 arst_n  input  1  asynchronous active-low reset.
REQ-004 opcode  input  6  instruction[31:26], taken from the instruction register, stable from DECODE until the next FETCH.
REQ-005 mem_ready  input  1  memory handshake; the access completes in a cycle where it is high.
REQ-006 pc_write, pc_write_cond, iord, ir_write, mem_read, mem_write, mem_2_reg, reg_dst, reg_write, alu_src_a  output  1 each  datapath controls.
REQ-007 alu_src_b  output  2  ALU B-mux select: 00=reg B, 01=constant 4, 10=sign-extended imm, 11=imm<<2.
REQ-008 alu_op  output  2  00=add, 01=sub, 10=R-type funct.
REQ-009 pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-010 instr_done  output  1  one-cycle pulse on the final cycle of each legal instruction.
REQ-011 illegal_op  output  1  one-cycle pulse for an unsupported opcode.
REQ-012 state  output  4  current state, debug only.

Function
REQ-013 Controller: registered state register plus combinational output decode; any output not listed for a state SHALL be 0.
REQ-014 State encoding: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, ALU_WB=8, BRANCH=9, JUMP=10, ADDI_EX=11, ADDI_WB=12.
REQ-015 IDLE: all outputs 0; next state FETCH.
REQ-016 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
REQ-017 In FETCH, ir_write and pc_write SHALL be asserted only in a cycle with mem_ready=1; the FSM holds in FETCH while mem_ready=0 and moves to DECODE when mem_ready=1.
REQ-018 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
REQ-019 DECODE next state by opcode: 0x23 or 0x2B -> MEM_ADDR; 0x00 -> EXECUTE; 0x04 -> BRANCH; 0x02 -> JUMP; 0x08 -> ADDI_EX.
REQ-020 Any other opcode in DECODE: illegal_op=1 for that cycle and next state FETCH.
REQ-021 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next state MEM_READ if opcode=0x23, else MEM_WRITE.
REQ-022 MEM_READ: mem_read=1, iord=1; hold while mem_ready=0; move to MEM_WB when mem_ready=1.
REQ-023 MEM_WB: reg_dst=0, mem_2_reg=1, reg_write=1, instr_done=1; next state FETCH.
REQ-024 MEM_WRITE: mem_write=1, iord=1; hold while mem_ready=0; when mem_ready=1, instr_done=1 and next state FETCH.
REQ-025 EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10; next state ALU_WB.
REQ-026 ALU_WB: reg_dst=1, mem_2_reg=0, reg_write=1, instr_done=1; next state FETCH.
REQ-027 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1; next state FETCH.
REQ-028 JUMP: pc_write=1, pc_source=10, instr_done=1; next state FETCH.
REQ-029 ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00; next state ADDI_WB.
REQ-030 ADDI_WB: reg_dst=0, mem_2_reg=0, reg_write=1, instr_done=1; next state FETCH.
REQ-031 Unused encodings 13-15: all outputs 0; next state IDLE.
REQ-032 Latency with mem_ready held high: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles; illegal opcode 2 cycles.
REQ-033 mem_ready SHALL be ignored in every state except FETCH, MEM_READ and MEM_WRITE.
REQ-034 instr_done and illegal_op SHALL never be high in the same cycle.

Reset
REQ-035 While arst_n=0, state SHALL be IDLE immediately, regardless of clk, and all outputs SHALL be 0.
REQ-036 Reset asserted mid-instruction SHALL abort it with no further write-enable pulses; the first clk edge after release moves the FSM to FETCH.

Verification
REQ-037 Reset release, mem_ready=1, opcode=0x23 -> states 0,1,2,3,4,5,1; reg_write=1 and mem_2_reg=1 only in state 5.
REQ-038 FETCH with mem_ready=0 for 3 cycles then 1 -> state stays 1 for 4 cycles; ir_write=pc_write=1 only in the 4th cycle.
REQ-039 opcode=0x04 -> states 1,2,9,1; pc_write_cond=1, alu_op=01, pc_source=01 in state 9; instr_done=1 in state 9.
REQ-040 opcode=0x2B with mem_ready low for 2 cycles in MEM_WRITE -> mem_write=1 for 3 cycles; instr_done=1 on the last cycle only.
REQ-041 opcode=0x3F -> states 1,2,1; illegal_op=1 in state 2; no write enable asserted.
REQ-042 arst_n pulsed low in state 4 -> state=0 asynchronously with outputs 0, then FETCH on the first edge after release.
